// File: rtl/mem_arbiter_pkg.sv
// Shared types for the unified-memory arbiter: FSM states, transaction owner
// and the largest memory read latency the latency counter is sized for.
package quinta_mem_pkg;

  localparam int MEM_LATENCY_MAX = 4;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } arb_state_t;

  typedef enum logic {
    OWNER_I,
    OWNER_D
  } arb_owner_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// Fetch, data and memory-side signals of the arbiter, bundled as one interface.
// The slave modport is the arbiter; master is the core/memory environment.
interface mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic                  i_req;
  logic [ADDR_W-1:0]     i_addr;
  logic                  i_ready;
  logic                  i_rvalid;
  logic [DATA_W-1:0]     i_rdata;

  logic                  d_req;
  logic                  d_we;
  logic [DATA_W/8-1:0]   d_be;
  logic [ADDR_W-1:0]     d_addr;
  logic [DATA_W-1:0]     d_wdata;
  logic                  d_ready;
  logic                  d_rvalid;
  logic [DATA_W-1:0]     d_rdata;

  logic                  m_en;
  logic                  m_we;
  logic [DATA_W/8-1:0]   m_be;
  logic [ADDR_W-1:0]     m_addr;
  logic [DATA_W-1:0]     m_wdata;
  logic [DATA_W-1:0]     m_rdata;

  logic                  busy;

  modport master (
    output i_req, i_addr, d_req, d_we, d_be, d_addr, d_wdata, m_rdata,
    input  i_ready, i_rvalid, i_rdata, d_ready, d_rvalid, d_rdata,
    input  m_en, m_we, m_be, m_addr, m_wdata, busy
  );

  modport slave (
    input  i_req, i_addr, d_req, d_we, d_be, d_addr, d_wdata, m_rdata,
    output i_ready, i_rvalid, i_rdata, d_ready, d_rvalid, d_rdata,
    output m_en, m_we, m_be, m_addr, m_wdata, busy
  );
endinterface

// File: rtl/mem_arbiter_select.sv
// Priority decision between fetch and data, with the data-streak counter that
// keeps instruction fetch from starving under continuous data traffic.
module mem_arb_select
  import quinta_mem_pkg::*;
#(
  parameter int MAX_DATA_STREAK = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_req,
  input  logic       d_req,
  input  logic       arbitrate,
  output logic       o_grant,
  output arb_owner_t o_owner
);

  localparam int SW = $clog2(MAX_DATA_STREAK + 1);
  localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_DATA_STREAK);

  logic [SW-1:0] r_streak;
  logic          w_forceFetch;

  assign w_forceFetch = i_req && (r_streak == STREAK_MAX);
  assign o_grant      = arbitrate && (i_req || d_req);
  assign o_owner      = (d_req && !w_forceFetch) ? OWNER_D : OWNER_I;

  // Only contested data grants extend the streak; anything else restarts it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_streak <= '0;
    end else if (o_grant) begin
      if (o_owner == OWNER_I || !i_req) begin
        r_streak <= '0;
      end else if (r_streak != STREAK_MAX) begin
        r_streak <= r_streak + 1'b1;
      end
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Single-port memory arbiter: accepts one fetch or data transaction at a time,
// issues a one-cycle memory command and returns registered read data.
module mem_arbiter
  import quinta_mem_pkg::*;
#(
  parameter int ADDR_W          = 32,
  parameter int DATA_W          = 32,
  parameter int MEM_LATENCY     = 1,
  parameter int MAX_DATA_STREAK = 4
) (
  input logic          clk,
  input logic          rst,
  mem_arbiter_if.slave bus
);

  localparam int BE_W  = DATA_W / 8;
  localparam int CNT_W = $clog2(MEM_LATENCY_MAX + 1);

  arb_state_t          r_state;
  arb_state_t          w_next;
  arb_owner_t          r_owner;
  arb_owner_t          w_owner;
  logic                w_grant;
  logic                w_arbitrate;
  logic [CNT_W-1:0]    r_cnt;

  logic                r_mEn;
  logic                r_mWe;
  logic [BE_W-1:0]     r_mBe;
  logic [ADDR_W-1:0]   r_mAddr;
  logic [DATA_W-1:0]   r_mWdata;
  logic                r_iRvalid;
  logic                r_dRvalid;
  logic [DATA_W-1:0]   r_iRdata;
  logic [DATA_W-1:0]   r_dRdata;

  assign w_arbitrate = (r_state == IDLE);

  mem_arb_select #(
    .MAX_DATA_STREAK(MAX_DATA_STREAK)
  ) u_select (
    .clk      (clk),
    .rst      (rst),
    .i_req    (bus.i_req),
    .d_req    (bus.d_req),
    .arbitrate(w_arbitrate),
    .o_grant  (w_grant),
    .o_owner  (w_owner)
  );

  // Ready is the only combinational output; it is forced low while in reset.
  assign bus.i_ready  = w_grant && (w_owner == OWNER_I) && !rst;
  assign bus.d_ready  = w_grant && (w_owner == OWNER_D) && !rst;
  assign bus.busy     = (r_state != IDLE);
  assign bus.m_en     = r_mEn;
  assign bus.m_we     = r_mWe;
  assign bus.m_be     = r_mBe;
  assign bus.m_addr   = r_mAddr;
  assign bus.m_wdata  = r_mWdata;
  assign bus.i_rvalid = r_iRvalid;
  assign bus.i_rdata  = r_iRdata;
  assign bus.d_rvalid = r_dRvalid;
  assign bus.d_rdata  = r_dRdata;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // During ISSUE r_mWe still holds the accepted command, so stores skip WAIT.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_grant) w_next = ISSUE;
      ISSUE:   w_next = r_mWe ? IDLE : WAIT;
      WAIT:    if (r_cnt == CNT_W'(1)) w_next = RESP;
      RESP:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_owner   <= OWNER_I;
      r_cnt     <= '0;
      r_mEn     <= 1'b0;
      r_mWe     <= 1'b0;
      r_mBe     <= '0;
      r_mAddr   <= '0;
      r_mWdata  <= '0;
      r_iRvalid <= 1'b0;
      r_dRvalid <= 1'b0;
      r_iRdata  <= '0;
      r_dRdata  <= '0;
    end else begin
      r_mEn     <= 1'b0;
      r_mWe     <= 1'b0;
      r_iRvalid <= 1'b0;
      r_dRvalid <= 1'b0;
      if (w_grant) begin
        r_owner <= w_owner;
        r_mEn   <= 1'b1;
        if (w_owner == OWNER_D) begin
          r_mWe    <= bus.d_we;
          r_mBe    <= bus.d_we ? bus.d_be : '1;
          r_mAddr  <= bus.d_addr;
          r_mWdata <= bus.d_wdata;
        end else begin
          r_mBe    <= '1;
          r_mAddr  <= bus.i_addr;
        end
      end
      if (r_state == ISSUE) begin
        r_cnt <= CNT_W'(MEM_LATENCY);
      end else if (r_state == WAIT) begin
        r_cnt <= r_cnt - 1'b1;
        if (r_cnt == CNT_W'(1)) begin
          if (r_owner == OWNER_I) begin
            r_iRdata  <= bus.m_rdata;
            r_iRvalid <= 1'b1;
          end else begin
            r_dRdata  <= bus.m_rdata;
            r_dRvalid <= 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Testbench for mem_arbiter: arbitration table, directed multi-cycle sequences
// and a randomized run against a transaction-level reference model.
module tb_mem_arbiter;
  import quinta_mem_pkg::*;

  localparam int AW   = 32;
  localparam int DW   = 32;
  localparam int LAT  = 2;
  localparam int MAXS = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  mem_arbiter #(
    .ADDR_W(AW), .DATA_W(DW), .MEM_LATENCY(LAT), .MAX_DATA_STREAK(MAXS)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  int nVec = 0;
  int nErr = 0;
  int cyc  = 0;
  int exclViol = 0;

  logic [31:0] envMem   [256];
  bit          envValid [256];
  logic [31:0] pipe     [LAT];
  logic [31:0] refMem   [256];

  function automatic logic [31:0] initWord(input int i);
    logic [7:0] a;
    a = i[7:0];
    if (i == 64) return 32'h0050_0093;
    return {a, ~a, 8'h5A, a ^ 8'h3C};
  endfunction

  function automatic logic [31:0] mergeBe(input logic [31:0] old, input logic [3:0] be,
                                          input logic [31:0] data);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = data[8*b +: 8];
    return r;
  endfunction

  function automatic logic [31:0] envRead(input logic [7:0] idx);
    return envValid[idx] ? envMem[idx] : initWord(int'(idx));
  endfunction

  // Memory with LAT cycles of read latency measured from the m_en edge.
  assign bus.m_rdata = pipe[LAT-1];
  always @(posedge clk) begin
    if (bus.m_en && bus.m_we) begin
      envMem[bus.m_addr[9:2]]   <= mergeBe(envRead(bus.m_addr[9:2]), bus.m_be, bus.m_wdata);
      envValid[bus.m_addr[9:2]] <= 1'b1;
    end
    pipe[0] <= (bus.m_en && !bus.m_we) ? envRead(bus.m_addr[9:2]) : 32'hDEAD_0000;
    for (int k = 1; k < LAT; k++) pipe[k] <= pipe[k-1];
  end

  always @(negedge clk) begin
    #2;
    if (bus.i_ready && bus.d_ready) exclViol++;
  end

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    nVec++;
    if (act !== exp) begin
      nErr++;
      $display("[TB] FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  task automatic applyStimulus(input logic iReq, input logic [31:0] iAddr, input logic dReq,
                               input logic dWe, input logic [3:0] dBe,
                               input logic [31:0] dAddr, input logic [31:0] dWdata);
    bus.i_req   = iReq;
    bus.i_addr  = iAddr;
    bus.d_req   = dReq;
    bus.d_we    = dWe;
    bus.d_be    = dBe;
    bus.d_addr  = dAddr;
    bus.d_wdata = dWdata;
  endtask

  task automatic idleInputs();
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
  endtask

  task automatic refWrite(input logic [31:0] addr, input logic [3:0] be, input logic [31:0] data);
    refMem[addr[9:2]] = mergeBe(refMem[addr[9:2]], be, data);
  endtask

  task automatic waitIdle();
    int k = 0;
    while (bus.busy && k < 50) begin
      tick();
      k++;
    end
    if (k >= 50) checkOutput("waitIdleTimeout", 64'(bus.busy), 64'h0);
  endtask

  typedef struct {
    logic iReq;
    logic dReq;
    logic expI;
    logic expD;
  } arbVec_t;

  typedef struct {
    int          due;
    arb_owner_t  owner;
    logic [31:0] data;
  } resp_t;

  initial begin
    arbVec_t     vecs [4];
    arb_owner_t  seq  [6];
    arb_owner_t  expSeq [6];
    resp_t       respQ [$];
    int          grants, budget, pulses;
    logic [31:0] expData;

    for (int i = 0; i < 256; i++) refMem[i] = initWord(i);
    vecs[0] = '{1'b0, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{1'b1, 1'b0, 1'b1, 1'b0};
    vecs[2] = '{1'b0, 1'b1, 1'b0, 1'b1};
    vecs[3] = '{1'b1, 1'b1, 1'b0, 1'b1};
    expSeq  = '{OWNER_D, OWNER_D, OWNER_D, OWNER_D, OWNER_I, OWNER_D};

    // Reset state, including ready held low while reset is asserted.
    rst = 1'b1;
    applyStimulus(1'b1, 32'h100, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    repeat (2) @(negedge clk);
    #1;
    checkOutput("rstIReady", 64'(bus.i_ready), 64'h0);
    checkOutput("rstBusy", 64'(bus.busy), 64'h0);
    checkOutput("rstMEn", 64'(bus.m_en), 64'h0);
    checkOutput("rstIRdata", 64'(bus.i_rdata), 64'h0);
    idleInputs();
    @(negedge clk);
    rst = 1'b0;

    for (int k = 0; k < 4; k++) begin
      applyStimulus(vecs[k].iReq, 32'h100, vecs[k].dReq, 1'b0, 4'hF, 32'h40, 32'h0);
      #1;
      checkOutput($sformatf("tblIReady[%0d]", k), 64'(bus.i_ready), 64'(vecs[k].expI));
      checkOutput($sformatf("tblDReady[%0d]", k), 64'(bus.d_ready), 64'(vecs[k].expD));
      idleInputs();
    end
    tick();

    // Lone fetch
    applyStimulus(1'b1, 32'h100, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    #1;
    checkOutput("fetchReady", 64'(bus.i_ready), 64'h1);
    tick();
    idleInputs();
    checkOutput("fetchMEn", 64'(bus.m_en), 64'h1);
    checkOutput("fetchMWe", 64'(bus.m_we), 64'h0);
    checkOutput("fetchMAddr", 64'(bus.m_addr), 64'h100);
    checkOutput("fetchMBe", 64'(bus.m_be), 64'hF);
    tick();
    checkOutput("fetchRvalidT2", 64'(bus.i_rvalid), 64'h0);
    tick();
    checkOutput("fetchRvalidT3", 64'(bus.i_rvalid), 64'h0);
    tick();
    checkOutput("fetchRvalidT4", 64'(bus.i_rvalid), 64'h1);
    checkOutput("fetchRdataT4", 64'(bus.i_rdata), 64'h0050_0093);
    tick();
    applyStimulus(1'b1, 32'h100, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    #1;
    checkOutput("fetchReadyT5", 64'(bus.i_ready), 64'h1);

    // Store, then read the same word back
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b1, 4'h3, 32'h2004, 32'hCAFE_BABE);
    #1;
    checkOutput("storeReady", 64'(bus.d_ready), 64'h1);
    tick();
    idleInputs();
    refWrite(32'h2004, 4'h3, 32'hCAFE_BABE);
    checkOutput("storeMEn", 64'(bus.m_en), 64'h1);
    checkOutput("storeMWe", 64'(bus.m_we), 64'h1);
    checkOutput("storeMBe", 64'(bus.m_be), 64'h3);
    checkOutput("storeMAddr", 64'(bus.m_addr), 64'h2004);
    checkOutput("storeMWdata", 64'(bus.m_wdata), 64'hCAFE_BABE);
    checkOutput("storeRvalidT1", 64'(bus.d_rvalid), 64'h0);
    tick();
    checkOutput("storeRvalidT2", 64'(bus.d_rvalid), 64'h0);
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 4'h0, 32'h2004, 32'h0);
    #1;
    checkOutput("storeReadyT2", 64'(bus.d_ready), 64'h1);
    tick();
    idleInputs();
    checkOutput("loadMBe", 64'(bus.m_be), 64'hF);
    checkOutput("loadMWe", 64'(bus.m_we), 64'h0);
    repeat (3) tick();
    checkOutput("loadRvalid", 64'(bus.d_rvalid), 64'h1);
    checkOutput("loadRdata", 64'(bus.d_rdata), 64'(refMem[1]));
    waitIdle();

    // Contention: both requesting continuously
    applyStimulus(1'b1, 32'h100, 1'b1, 1'b0, 4'hF, 32'h40, 32'h0);
    grants = 0;
    budget = 0;
    while (grants < 6 && budget < 200) begin
      #1;
      if (bus.i_ready) begin
        seq[grants] = OWNER_I;
        grants++;
      end else if (bus.d_ready) begin
        seq[grants] = OWNER_D;
        grants++;
      end
      tick();
      budget++;
    end
    idleInputs();
    checkOutput("contentionGrants", 64'(grants), 64'h6);
    for (int k = 0; k < grants; k++)
      checkOutput($sformatf("contentionGrant[%0d]", k), 64'(seq[k]), 64'(expSeq[k]));
    waitIdle();

    // Reset during WAIT of a data load
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 4'h0, 32'h40, 32'h0);
    tick();
    idleInputs();
    tick();
    checkOutput("preRstBusy", 64'(bus.busy), 64'h1);
    rst = 1'b1;
    #1;
    checkOutput("midRstBusy", 64'(bus.busy), 64'h0);
    checkOutput("midRstIRdata", 64'(bus.i_rdata), 64'h0);
    checkOutput("midRstDRdata", 64'(bus.d_rdata), 64'h0);
    tick();
    rst = 1'b0;
    pulses = 0;
    for (int k = 0; k < 4; k++) begin
      if (bus.d_rvalid) pulses++;
      tick();
    end
    checkOutput("rstNoDRvalid", 64'(pulses), 64'h0);
    applyStimulus(1'b1, 32'h80, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    #1;
    checkOutput("postRstReady", 64'(bus.i_ready), 64'h1);
    tick();
    idleInputs();
    repeat (3) tick();
    checkOutput("postRstRvalid", 64'(bus.i_rvalid), 64'h1);
    checkOutput("postRstRdata", 64'(bus.i_rdata), 64'(refMem[32]));
    waitIdle();

    // Fetch request dropped while busy must never reach memory
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 4'h0, 32'h44, 32'h0);
    tick();
    idleInputs();
    tick();
    applyStimulus(1'b1, 32'h300, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    #1;
    checkOutput("dropReady", 64'(bus.i_ready), 64'h0);
    tick();
    idleInputs();
    pulses = 0;
    for (int k = 0; k < 6; k++) begin
      if (bus.m_en) pulses++;
      tick();
    end
    checkOutput("dropNoAccess", 64'(pulses), 64'h0);
    waitIdle();

    // Randomized traffic against a transaction-level model
    begin
      int          nextFree = cyc;
      int          streakM  = 0;
      int          menDue   = -1;
      bit          iPend = 0, dPend = 0, dWe = 0;
      logic [31:0] iAddr = 0, dAddr = 0, dWdata = 0;
      logic [3:0]  dBe = 0;
      bit          expI, expD, expIv, expDv;
      for (int n = 0; n < 1500; n++) begin
        if (n < 1490) begin
          if (!iPend && $urandom_range(0, 2) == 0) begin
            iPend = 1;
            iAddr = 32'($urandom_range(0, 255)) << 2;
          end else if (iPend && $urandom_range(0, 15) == 0) iPend = 0;
          if (!dPend && $urandom_range(0, 1) == 0) begin
            dPend  = 1;
            dWe    = $urandom_range(0, 1) == 1;
            dBe    = 4'($urandom_range(1, 15));
            dAddr  = 32'($urandom_range(0, 255)) << 2;
            dWdata = $urandom;
          end else if (dPend && $urandom_range(0, 15) == 0) dPend = 0;
        end else begin
          iPend = 0;
          dPend = 0;
        end
        applyStimulus(iPend, iAddr, dPend, dWe, dBe, dAddr, dWdata);
        #1;
        expI = 0;
        expD = 0;
        if (cyc >= nextFree && (iPend || dPend)) begin
          if (dPend && !(iPend && streakM == MAXS)) expD = 1;
          else expI = 1;
        end
        checkOutput("rndIReady", 64'(bus.i_ready), 64'(expI));
        checkOutput("rndDReady", 64'(bus.d_ready), 64'(expD));
        checkOutput("rndMEn", 64'(bus.m_en), 64'(cyc == menDue));
        expIv = 0;
        expDv = 0;
        expData = 0;
        if (respQ.size() > 0 && respQ[0].due == cyc) begin
          expIv = (respQ[0].owner == OWNER_I);
          expDv = (respQ[0].owner == OWNER_D);
          expData = respQ[0].data;
          void'(respQ.pop_front());
        end
        checkOutput("rndIRvalid", 64'(bus.i_rvalid), 64'(expIv));
        checkOutput("rndDRvalid", 64'(bus.d_rvalid), 64'(expDv));
        if (expIv) checkOutput("rndIRdata", 64'(bus.i_rdata), 64'(expData));
        if (expDv) checkOutput("rndDRdata", 64'(bus.d_rdata), 64'(expData));
        if (expI || expD) begin
          menDue = cyc + 1;
          if (expI) streakM = 0;
          else streakM = iPend ? ((streakM < MAXS) ? streakM + 1 : MAXS) : 0;
          if (expD && dWe) begin
            refWrite(dAddr, dBe, dWdata);
            nextFree = cyc + 2;
          end else begin
            respQ.push_back('{cyc + LAT + 2, expI ? OWNER_I : OWNER_D,
                              refMem[expI ? iAddr[9:2] : dAddr[9:2]]});
            nextFree = cyc + LAT + 3;
          end
          if (expI) iPend = 0;
          else dPend = 0;
        end
        tick();
      end
      checkOutput("rndRespDrained", 64'(respQ.size()), 64'h0);
    end

    checkOutput("readyExclusive", 64'(exclViol), 64'h0);
    $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
    $finish;
  end

endmodule
